// File: rtl/commit_pkg.sv
// Shared definitions for the multi-port commit stage: default widths,
// the buffered result entry and the round-robin pointer helper.
package commit_pkg;

    localparam int XLEN_DEF = 64;
    localparam int RN_W_DEF = 6;

    typedef struct packed {
        logic [RN_W_DEF-1:0] rn;
        logic [XLEN_DEF-1:0] data;
    } commit_entry_t;

    // Next round-robin start position after channel ch, wrapping at n
    function automatic int unsigned rr_next(input int unsigned ch, input int unsigned n);
        return (ch + 1 >= n) ? 0 : ch + 1;
    endfunction

endpackage

// File: rtl/commit_chan_fifo.sv
// Single-channel result FIFO of DEPTH entries (DEPTH a power of two).
// Head is read straight from storage so the arbiter sees registered state.
module commit_chan_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 70
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    // Storage, pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/commit_arbiter.sv
// Multi-port commit stage: per-channel result FIFOs drained round-robin onto
// NUM_WP register-file write ports, never two writes to one register per cycle.
// Optional feature macro: COMMIT_BYPASS_EN (empty channel may be granted
// straight from its input, giving a one-cycle uncontended latency).
module commit_arbiter
    import commit_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int NUM_WP = 2,
    parameter int DEPTH  = 2,
    parameter int XLEN   = XLEN_DEF,
    parameter int RN_W   = RN_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*RN_W-1:0]   ch_rn,
    input  logic [NUM_CH*XLEN-1:0]   ch_data,
    output logic [NUM_CH-1:0]        ch_stall,
    output logic [NUM_WP-1:0]        wr_en,
    output logic [NUM_WP*RN_W-1:0]   wr_rn,
    output logic [NUM_WP*XLEN-1:0]   wr_data,
    output logic                     busy
);

    localparam int PTR_W = $clog2(NUM_CH);
    localparam int EW    = RN_W + XLEN;

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] grant;
    logic [EW-1:0]     head [NUM_CH];

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  last_ch;
    logic              any_grant;
    logic [NUM_WP-1:0] sel_en;
    logic [RN_W-1:0]   sel_rn   [NUM_WP];
    logic [XLEN-1:0]   sel_data [NUM_WP];

    int unsigned       nports;
    int unsigned       c_idx;
    logic              req;
    logic              coll;
    logic [RN_W-1:0]   cand_rn;
    logic [XLEN-1:0]   cand_data;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_fifo
        commit_chan_fifo #(
            .DEPTH (DEPTH),
            .W     (EW)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   ({ch_rn[i*RN_W +: RN_W], ch_data[i*XLEN +: XLEN]}),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
    end

    // Round-robin scan from rr_ptr; a candidate whose rn matches an earlier grant waits
    always_comb begin
        grant     = '0;
        sel_en    = '0;
        any_grant = 1'b0;
        last_ch   = '0;
        nports    = 0;
        c_idx     = 0;
        req       = 1'b0;
        coll      = 1'b0;
        cand_rn   = '0;
        cand_data = '0;
        for (int unsigned p = 0; p < NUM_WP; p++) begin
            sel_rn[p]   = '0;
            sel_data[p] = '0;
        end
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            c_idx     = (32'(rr_ptr) + k) % NUM_CH;
            cand_rn   = head[c_idx][EW-1 -: RN_W];
            cand_data = head[c_idx][XLEN-1:0];
            req       = !empty[c_idx];
`ifdef COMMIT_BYPASS_EN
            if (empty[c_idx]) begin
                cand_rn   = ch_rn[c_idx*RN_W +: RN_W];
                cand_data = ch_data[c_idx*XLEN +: XLEN];
                req       = ch_valid[c_idx] && (ch_rn[c_idx*RN_W +: RN_W] != '0);
            end
`endif
            coll = 1'b0;
            for (int unsigned q = 0; q < NUM_WP; q++) begin
                if (q < nports && sel_rn[q] == cand_rn) coll = 1'b1;
            end
            if (req && !coll && nports < NUM_WP) begin
                grant[c_idx]     = 1'b1;
                sel_en[nports]   = 1'b1;
                sel_rn[nports]   = cand_rn;
                sel_data[nports] = cand_data;
                nports           = nports + 1;
                any_grant        = 1'b1;
                last_ch          = PTR_W'(c_idx);
            end
        end
    end

    // Enqueue non-zero rn when not full; a bypass grant consumes the input instead
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pop[i]  = grant[i] && !empty[i];
            push[i] = ch_valid[i] && !full[i] && (ch_rn[i*RN_W +: RN_W] != '0) &&
                      !(grant[i] && empty[i]);
        end
    end

    // Output registers and round-robin pointer; idle ports keep their last data
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            wr_en   <= '0;
            wr_rn   <= '0;
            wr_data <= '0;
        end else begin
            if (any_grant) rr_ptr <= PTR_W'(rr_next(32'(last_ch), NUM_CH));
            wr_en <= sel_en;
            for (int unsigned p = 0; p < NUM_WP; p++) begin
                wr_rn[p*RN_W +: RN_W] <= sel_rn[p];
                if (sel_en[p]) wr_data[p*XLEN +: XLEN] <= sel_data[p];
            end
        end
    end

    assign ch_stall = full;
    assign busy     = |(~empty);

endmodule
